// File: rtl/popcnt_frame_accum.sv
// rtl/popcnt_frame_accum.sv - frame accumulator for csa popcount beats
//
// Purpose: sums per-beat popcounts ({cy,sum}) over a frame of up to
// FRAME_LEN beats, tracks the frame maximum and beat count, and presents the
// result on a registered valid/ready output. Input is backpressured while a
// result is held.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  popcount beat handshake
//   in_cy, in_sum      csa carry and sum; count = {in_cy,in_sum}
//   in_last            beat closes the frame early
//   out_valid/out_ready result handshake
//   out_total          sum of counts in the frame
//   out_max            largest single count in the frame
//   out_beats          number of beats in the frame
//   err                sticky illegal-input flag (in_cy=1 with in_sum!=0)
module popcnt_frame_accum #(
  parameter int DEPTH     = 64,
  parameter int WIDTH     = $clog2(DEPTH + 1),
  parameter int FRAME_LEN = 16,
  parameter int ACC_W     = $clog2(DEPTH * FRAME_LEN + 1),
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_cy,
  input  logic [WIDTH-2:0] in_sum,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [WIDTH-1:0] out_max,
  output logic [CNT_W-1:0] out_beats,
  output logic             err
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic [ACC_W-1:0] total_q, total_d;
  logic [WIDTH-1:0] omax_q, omax_d;
  logic [CNT_W-1:0] obeats_q, obeats_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] count;
  logic             illegal;
  logic             accept;
  logic [ACC_W-1:0] acc_upd;
  logic [WIDTH-1:0] max_upd;
  logic [CNT_W-1:0] beats_upd;
  logic             close;

  // A set carry means the csa saw all DEPTH bits; any sum bits alongside it
  // are illegal, and the beat is still taken as a full DEPTH count.
  assign illegal   = in_cy && (in_sum != '0);
  assign count     = in_cy ? WIDTH'(DEPTH) : {1'b0, in_sum};
  assign accept    = in_valid && (state_q == ACCUM);
  assign acc_upd   = acc_q + ACC_W'(count);
  assign max_upd   = (count > max_q) ? count : max_q;
  assign beats_upd = beats_q + CNT_W'(1);
  assign close     = in_last || (beats_upd == CNT_W'(FRAME_LEN));

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    max_d    = max_q;
    beats_d  = beats_q;
    total_d  = total_q;
    omax_d   = omax_q;
    obeats_d = obeats_q;
    err_d    = err_q | (accept & illegal);
    in_ready = 1'b0;

    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (accept) begin
          if (close) begin
            total_d  = acc_upd;
            omax_d   = max_upd;
            obeats_d = beats_upd;
            acc_d    = '0;
            max_d    = '0;
            beats_d  = '0;
            state_d  = HOLD;
          end else begin
            acc_d   = acc_upd;
            max_d   = max_upd;
            beats_d = beats_upd;
          end
        end
      end
      HOLD: begin
        // Release only; a beat offered in this cycle waits for ACCUM.
        if (out_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ACCUM;
      acc_q    <= '0;
      max_q    <= '0;
      beats_q  <= '0;
      total_q  <= '0;
      omax_q   <= '0;
      obeats_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      max_q    <= max_d;
      beats_q  <= beats_d;
      total_q  <= total_d;
      omax_q   <= omax_d;
      obeats_q <= obeats_d;
      err_q    <= err_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_total = total_q;
  assign out_max   = omax_q;
  assign out_beats = obeats_q;
  assign err       = err_q;

endmodule
